armbus_scheduler: RTL

- Shares the single ARM motor-bus serial link (armbuscontrol rx/tx conduit) between N_REQ command requesters inside soc_system.
- Arbitrates round-robin, frames the winning command into a fixed 7-byte packet, and streams it byte-by-byte to the existing UART byte transmitter.
- Waits for a 1-byte acknowledge from the motor board, or times out, then reports the result to the originating requester.

---
 rtl/armbus_scheduler_pkg.sv | 22 ++
 rtl/armbus_scheduler_if.sv | 38 +++
 rtl/armbus_scheduler_rr_arbiter.sv | 31 +++
 rtl/armbus_scheduler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/armbus_scheduler_pkg.sv
// Shared types and constants for the ARM motor-bus scheduler.
// Holds the frame layout, the state encoding and the checksum.
package armbus_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam logic [7:0] ACK_OK_DEF = 8'h06;
  localparam int         FRAME_LEN  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND,
    ST_WAIT_ACK,
    ST_REPORT
  } state_e;

  // Trailing frame byte: XOR of the motor id and all four setpoint bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] id, input logic [31:0] data);
    return id ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction

endpackage

// File: rtl/armbus_scheduler_if.sv
// Requester, UART byte link and result signals of the motor-bus scheduler.
// The master modport is the scheduler side; slave is the SoC/UART side.
interface armbus_scheduler_if #(
  parameter int N_REQ = 4
);
  localparam int SRC_W = $clog2(N_REQ);

  logic                  enable;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [8*N_REQ-1:0]    req_id;
  logic [32*N_REQ-1:0]   req_data;

  logic [7:0]            tx_byte;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_byte;
  logic                  rx_valid;

  logic                  resp_valid;
  logic [SRC_W-1:0]      resp_src;
  logic                  resp_ok;
  logic                  resp_timeout;
  logic                  busy;

  modport master (
    input  enable, req_valid, req_id, req_data, tx_ready, rx_byte, rx_valid,
    output req_ready, tx_byte, tx_valid, resp_valid, resp_src, resp_ok,
           resp_timeout, busy
  );

  modport slave (
    output enable, req_valid, req_id, req_data, tx_ready, rx_byte, rx_valid,
    input  req_ready, tx_byte, tx_valid, resp_valid, resp_src, resp_ok,
           resp_timeout, busy
  );

endinterface

// File: rtl/armbus_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o                     = 1'b1;
        idx_o                       = cand[IDX_W-1:0];
        grant_o[cand[IDX_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/armbus_scheduler.sv
// Shares the motor-bus UART between N_REQ requesters: round-robin grant,
// 7-byte framing, then waits for a 1-byte ack or a timeout and reports it.
module armbus_scheduler
  import armbus_pkg::*;
#(
  parameter int         N_REQ   = 4,
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] HEADER  = HEADER_DEF,
  parameter logic [7:0] ACK_OK  = ACK_OK_DEF
) (
  input  logic               clock,
  input  logic               reset,
  armbus_scheduler_if.master bus
);

  localparam int          IDX_W     = $clog2(N_REQ);
  localparam logic [19:0] TMO_LAST  = 20'(TIMEOUT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] src_q, src_d;
  logic [7:0]       id_q, id_d;
  logic [31:0]      data_q, data_d;
  logic [7:0]       chk_q, chk_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [19:0]      timer_q, timer_d;
  logic             ok_q, ok_d;
  logic             tmo_q, tmo_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      src_q      <= '0;
      id_q       <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      ok_q       <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      src_q      <= src_d;
      id_q       <= id_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      ok_q       <= ok_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    id_d       = id_q;
    data_d     = data_q;
    chk_d      = chk_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    ok_d       = ok_q;
    tmo_d      = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.enable && |bus.req_valid) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        // A request withdrawn between IDLE and GRANT falls back without a grant.
        if (arb_valid) begin
          src_d      = arb_idx;
          id_d       = bus.req_id[int'(arb_idx)*8 +: 8];
          data_d     = bus.req_data[int'(arb_idx)*32 +: 32];
          chk_d      = frame_chk(id_d, data_d);
          rr_ptr_d   = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          byte_idx_d = '0;
          state_d    = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bus.tx_ready) begin
          if (byte_idx_q == LAST_BYTE) begin
            timer_d = '0;
            state_d = ST_WAIT_ACK;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      ST_WAIT_ACK: begin
        // An ack arriving on the final timer cycle still counts as an ack.
        if (bus.rx_valid) begin
          ok_d    = (bus.rx_byte == ACK_OK);
          tmo_d   = 1'b0;
          state_d = ST_REPORT;
        end else if (timer_q == TMO_LAST) begin
          ok_d    = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_REPORT;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.tx_valid     = 1'b0;
    bus.tx_byte      = '0;
    bus.resp_valid   = 1'b0;
    bus.resp_src     = '0;
    bus.resp_ok      = 1'b0;
    bus.resp_timeout = 1'b0;
    bus.busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_GRANT: begin
        bus.req_ready = arb_grant;
      end
      ST_SEND: begin
        bus.tx_valid = 1'b1;
        case (byte_idx_q)
          3'd0:    bus.tx_byte = HEADER;
          3'd1:    bus.tx_byte = id_q;
          3'd2:    bus.tx_byte = data_q[31:24];
          3'd3:    bus.tx_byte = data_q[23:16];
          3'd4:    bus.tx_byte = data_q[15:8];
          3'd5:    bus.tx_byte = data_q[7:0];
          default: bus.tx_byte = chk_q;
        endcase
      end
      ST_REPORT: begin
        bus.resp_valid   = 1'b1;
        bus.resp_src     = src_q;
        bus.resp_ok      = ok_q;
        bus.resp_timeout = tmo_q;
      end
      default: begin
      end
    endcase
  end

  a_resp_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(bus.resp_ok && bus.resp_timeout));

  a_ready_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(bus.req_ready));

  a_tx_hold: assert property (@(posedge clock) disable iff (reset)
    (bus.tx_valid && !bus.tx_ready) |=> (bus.tx_valid && $stable(bus.tx_byte)));

endmodule
